ahb_sram_slave: RTL

- AHB-Lite responder: a single-port word-organised on-chip SRAM that chip_top hangs off the core's AHB master.
- Sits behind the address decoder; it sees hsel_i plus the shared AHB bus.
- Provides programmable wait states and byte/halfword/word writes.
- Returns an ERROR response for illegal accesses.

---
 rtl/ahb_sram_slave.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised single-port array with
// programmable wait states, byte/halfword/word writes, ERROR on bad access.
module ahb_sram_slave #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk_i,
    input  logic        hreset_i,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic [31:0] hrdata_o,
    output logic        hreadyout_o,
    output logic        hresp_o
);
    localparam int AW    = DEPTH_LOG2 + 2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] WS_LOAD =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      cnt;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [1:0]      size_q;
    logic [31:0]     rdata_q;
    logic [3:0]      be;
    logic            take;
    logic            open;
    logic            accept;
    logic            legal;
    logic [31:0]     word;
    logic [31:0]     mem [DEPTH];

    assign take   = hsel_i & hready_i & htrans_i[1];
    assign open   = (state != S_WAIT) && (state != S_ERR1);
    assign accept = take & open;
    assign word   = mem[addr_q[AW-1:2]];

    // Legality of the transfer presented in the current address phase
    always_comb begin
        legal = 1'b1;
        if (hsize_i > 3'd2)
            legal = 1'b0;
        if (hsize_i == 3'd1 && haddr_i[0])
            legal = 1'b0;
        if (hsize_i == 3'd2 && haddr_i[1:0] != 2'b00)
            legal = 1'b0;
        if (haddr_i[31:AW] != '0)
            legal = 1'b0;
    end

    // State register
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; IDLE, DONE and ERR2 all accept a new transfer
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_WAIT: begin
                if (cnt == 3'd0)
                    state_nxt = S_DONE;
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (!take)
                    state_nxt = S_IDLE;
                else if (!legal)
                    state_nxt = S_ERR1;
                else if (WAIT_STATES == 0)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_WAIT;
            end
        endcase
    end

    // Address-phase capture and wait-state countdown
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            cnt     <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
        end else if (accept) begin
            cnt     <= WS_LOAD;
            addr_q  <= haddr_i[AW-1:0];
            write_q <= hwrite_i;
            size_q  <= hsize_i[1:0];
        end else if (state == S_WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Byte-lane enables for the captured write
    always_comb begin
        be = 4'b0000;
        unique case (size_q)
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Array write on the completing cycle of a write; contents survive reset
    always_ff @(posedge hclk_i) begin
        if (state == S_DONE && write_q) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem[addr_q[AW-1:2]][8*k +: 8] <= hwdata_i[8*k +: 8];
            end
        end
    end

    // Hold the last read word so hrdata_o is stable between reads
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i)
            rdata_q <= 32'd0;
        else if (state == S_DONE && !write_q)
            rdata_q <= word;
    end

    // Bus response outputs; read data comes straight from the array
    always_comb begin
        hreadyout_o = !(state == S_WAIT || state == S_ERR1);
        hresp_o     = (state == S_ERR1) || (state == S_ERR2);
        hrdata_o    = rdata_q;
        if (state == S_DONE && !write_q)
            hrdata_o = word;
    end
endmodule
